noc_output_arbiter: RTL
=======================

Name: noc_output_arbiter

Overview:
- Round-robin wormhole switch allocator directly downstream of the NoC input queues.
- Watches the head flit of N_IN first-word-fall-through queues and pops one queue per cycle into a registered output stage.
- Once a head flit is granted, the grant is locked to that queue until its tail flit passes, so packets never interleave.
- The output drives the router link or crossbar with a valid/ready handshake.

Parameters:
- N_IN, 4, number of input queues arbitrated (2..8).
- FLIT_W, 34, flit width. Bits [FLIT_W-1:FLIT_W-2] are the flit type; the remaining bits are payload.
- IDX_W, $clog2(N_IN), width of the queue index.

Flit type encoding: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail in one flit).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- q_empty  in  N_IN  per-queue empty flag; bit i belongs to queue i.
- q_data  in  N_IN*FLIT_W  head flit of each queue; queue i occupies slice [i*FLIT_W +: FLIT_W]; valid whenever q_empty[i]=0.
- q_re  out  N_IN  pop strobe, combinational, at most one bit high; the queue pops on the same clk edge.
- out_valid  out  1  output flit valid.
- out_flit  out  FLIT_W  output flit, registered.
- out_ready  in  1  downstream accepts out_flit this cycle.
- lock_valid  out  1  high while in LOCKED state.
- lock_id  out  IDX_W  queue currently holding the lock.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: rst_n low asynchronously clears all of the following.
  - state=IDLE, rr_ptr=0.
  - out_valid=0, out_flit=0.
  - lock_valid=0, lock_id=0, proto_err=0.
  - q_re=0 while rst_n is low.
  - Any packet in flight is abandoned; no pop occurs during reset.
- Load condition: can_load = !out_valid || out_ready.
  - The output register holds out_flit stable while out_valid && !out_ready.
  - Sustained throughput is 1 flit/cycle.
- Latency: a flit popped in cycle t appears on out_valid/out_flit in cycle t+1.
- IDLE state:
  - req[i] = !q_empty[i] && type(q_data[i]) is head or single.
  - Winner = first i with req[i]=1, searching circularly from rr_ptr.
  - If can_load and any req: q_re[winner]=1; at the clk edge out_flit<=q_data[winner], out_valid<=1, rr_ptr<=(winner+1) mod N_IN.
    - Winner flit type single: stay in IDLE.
    - Winner flit type head: go to LOCKED with lock_id=winner and lock_valid=1.
  - If !can_load: no pop and rr_ptr is unchanged.
  - If no req and can_load: out_valid<=0.
- LOCKED state:
  - Only queue lock_id is considered; all other queues are ignored.
  - If can_load && !q_empty[lock_id]: pop and load it. If the popped flit is a tail, go to IDLE and clear lock_valid.
  - If can_load && q_empty[lock_id]: bubble (out_valid<=0); stay in LOCKED.
  - rr_ptr does not change in LOCKED.
- Protocol errors:
  - In IDLE, a non-empty queue whose head is body or tail sets proto_err. The queue is not popped and not granted.
  - In LOCKED, a popped flit typed head or single sets proto_err. The flit is still forwarded, state stays LOCKED, and the lock is released only by a tail.
  - proto_err clears only on reset.
- Simultaneous events: when a pop and out_ready occur in the same cycle, the new flit replaces the accepted one with no bubble.
- Fairness: a queue that wins is lowest priority for the next arbitration. Every requester is served within N_IN packet grants.

Test Plan:
1. Reset and single flit: rst_n low, then high. Queue 2 presents a single flit 34'h3_0000_00AA.
   - Required: q_re=4'b0100 in the cycle the flit is presented.
   - Next cycle: out_valid=1, out_flit=34'h3_0000_00AA, rr_ptr=3, lock_valid=0.
2. Round robin: all 4 queues hold single flits, out_ready=1, rr_ptr=0.
   - Required: grant order 0,1,2,3,0 on consecutive cycles with no bubbles.
3. Wormhole lock: queue 1 holds head/body/body/tail; queue 0 holds a single flit; rr_ptr=1.
   - Required: queue 1's four flits leave consecutively with lock_id=1 throughout.
   - The queue 0 flit follows in the 5th output cycle.
4. Backpressure and bubble:
   - out_ready=0 for 3 cycles mid-packet: out_flit held, q_re=0 during the stall.
   - Locked queue empties for 2 cycles: out_valid drops, state stays LOCKED, and no other queue is granted even if it is non-empty.
5. Errors and reset mid-packet:
   - Queue 3 head is a body flit while IDLE: proto_err=1 and q_re[3] never asserts.
   - rst_n pulsed low while LOCKED: lock_valid=0, out_valid=0 and proto_err=0 immediately (asynchronous), with no pop during reset.

Source files
------------

// File: rtl/noc_output_arbiter_if.sv
// rtl/noc_output_arbiter_if.sv - queue-head and output-link bundle for the wormhole output arbiter
interface noc_output_arbiter_if #(
    parameter int N_IN   = 4,
    parameter int FLIT_W = 34,
    parameter int IDX_W  = $clog2(N_IN)
);
    logic [N_IN-1:0]        q_empty;
    logic [N_IN*FLIT_W-1:0] q_data;
    logic [N_IN-1:0]        q_re;
    logic                   out_valid;
    logic [FLIT_W-1:0]      out_flit;
    logic                   out_ready;
    logic                   lock_valid;
    logic [IDX_W-1:0]       lock_id;
    logic                   proto_err;

    // Arbiter side
    modport master (
        input  q_empty, q_data, out_ready,
        output q_re, out_valid, out_flit, lock_valid, lock_id, proto_err
    );

    // Queue/link side
    modport slave (
        output q_empty, q_data, out_ready,
        input  q_re, out_valid, out_flit, lock_valid, lock_id, proto_err
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - round-robin wormhole allocator popping FWFT queues into a registered output
module noc_output_arbiter #(
    parameter int N_IN   = 4,
    parameter int FLIT_W = 34,
    parameter int IDX_W  = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    noc_output_arbiter_if.master  bus
);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_lock_id;
    logic               r_out_valid;
    logic [FLIT_W-1:0]  r_out_flit;
    logic               r_proto_err;

    logic               w_can_load;
    logic [FLIT_W-1:0]  w_head [N_IN];
    logic [N_IN-1:0]    w_req;
    logic [N_IN-1:0]    w_bad;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_idx;
    logic               w_pop;
    logic [IDX_W-1:0]   w_pop_idx;
    logic [FLIT_W-1:0]  w_pop_flit;
    logic [1:0]         w_pop_type;
    logic [N_IN-1:0]    w_q_re;

    // The output register may take a new flit when empty or being drained this cycle
    assign w_can_load = !r_out_valid || bus.out_ready;

    // Classify each queue head: packet starts may request, anything else at a head is malformed
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_head[i] = bus.q_data[i*FLIT_W +: FLIT_W];
            w_req[i]  = !bus.q_empty[i] &&
                        ((w_head[i][FLIT_W-1 -: 2] == T_HEAD) || (w_head[i][FLIT_W-1 -: 2] == T_SINGLE));
            w_bad[i]  = !bus.q_empty[i] &&
                        ((w_head[i][FLIT_W-1 -: 2] == T_BODY) || (w_head[i][FLIT_W-1 -: 2] == T_TAIL));
        end
    end

    // Circular first-requester search starting at the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + k) % N_IN);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // State register; reset abandons any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a popped head opens a lock, only a popped tail closes it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_pop && (w_pop_type == T_HEAD)) w_state_nxt = S_LOCKED;
            S_LOCKED: if (w_pop && (w_pop_type == T_TAIL)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs of the FSM: which queue pops this cycle; no strobe may escape during reset
    always_comb begin
        w_pop     = 1'b0;
        w_pop_idx = w_win;
        w_q_re    = '0;
        if (r_state == S_IDLE) begin
            w_pop     = w_can_load && w_found;
            w_pop_idx = w_win;
        end else begin
            w_pop     = w_can_load && !bus.q_empty[r_lock_id];
            w_pop_idx = r_lock_id;
        end
        w_pop_flit = w_head[w_pop_idx];
        w_pop_type = w_pop_flit[FLIT_W-1 -: 2];
        if (w_pop && rst_n) begin
            w_q_re[w_pop_idx] = 1'b1;
        end
    end

    // Output stage, round-robin pointer, lock owner and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_rr_ptr    <= '0;
            r_lock_id   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_can_load) begin
                r_out_valid <= w_pop;
                if (w_pop) begin
                    r_out_flit <= w_pop_flit;
                end
            end
            if ((r_state == S_IDLE) && w_pop) begin
                r_rr_ptr <= (w_win == IDX_W'(N_IN - 1)) ? '0 : w_win + 1'b1;
                if (w_pop_type == T_HEAD) begin
                    r_lock_id <= w_win;
                end
            end
            if (((r_state == S_IDLE) && (|w_bad)) ||
                ((r_state == S_LOCKED) && w_pop &&
                 ((w_pop_type == T_HEAD) || (w_pop_type == T_SINGLE)))) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign bus.q_re       = w_q_re;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_flit   = r_out_flit;
    assign bus.lock_valid = (r_state == S_LOCKED);
    assign bus.lock_id    = r_lock_id;
    assign bus.proto_err  = r_proto_err;

endmodule
